// File: rtl/bin2bcd_11dig_pkg.sv
// Shared constants and types for the 36-bit binary to 11-digit BCD converter.
// Holds the default widths, the FSM state encodings and the BCD digit type.
package bin2bcd_11dig_pkg;

  localparam int BIN_W = 36;
  localparam int NDIG  = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bin2bcd_11dig_adj3.sv
// Double-dabble digit correction: any BCD digit above 4 gets 3 added before the shift,
// so a digit of at most 9 never produces a value above 12.
module bcd_adj3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_11dig.sv
// Sequential shift-and-add-3 converter: one shift per clock, BIN_W shifts per conversion.
// Digit outputs are direct register outputs and hold until the next accepted start.
module bin2bcd_11dig #(
  parameter int BIN_W = bin2bcd_11dig_pkg::BIN_W,
  parameter int NDIG  = bin2bcd_11dig_pkg::NDIG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic [3:0]       dig5,
  output logic [3:0]       dig6,
  output logic [3:0]       dig7,
  output logic [3:0]       dig8,
  output logic [3:0]       dig9,
  output logic [3:0]       dig10,
  output logic [1:0]       fsm_state
);

  import bin2bcd_11dig_pkg::*;

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int WIDE  = 4 * NDIG + BIN_W;

  state_t           state_q;
  logic             ready_q;
  logic             done_q;
  logic [BIN_W-1:0] sr_q;
  logic [CNT_W-1:0] n_q;
  bcd_t             dig_q [NDIG];
  logic [4*NDIG-1:0] adj_flat;
  logic [WIDE-1:0]  wide_next;

  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    bcd_adj3 u_adj (
      .digit (dig_q[i]),
      .adj   (adj_flat[4*i +: 4])
    );
  end

  // Corrected digits and the binary shift register move left as one word; the
  // carry out of the top digit falls off the end and is provably zero for 36 bits.
  assign wide_next = {adj_flat, sr_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sr_q    <= '0;
      n_q     <= '0;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q    <= bin;
            n_q     <= CNT_W'(BIN_W);
            ready_q <= 1'b0;
            state_q <= ST_OP;
            for (int i = 0; i < NDIG; i++) dig_q[i] <= '0;
          end
        end
        ST_OP: begin
          sr_q <= wide_next[BIN_W-1:0];
          for (int i = 0; i < NDIG; i++) dig_q[i] <= wide_next[BIN_W + 4*i +: 4];
          n_q <= n_q - CNT_W'(1);
          if (n_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_q;
  assign fsm_state = state_q;
  assign dig0  = dig_q[0];
  assign dig1  = dig_q[1];
  assign dig2  = dig_q[2];
  assign dig3  = dig_q[3];
  assign dig4  = dig_q[4];
  assign dig5  = dig_q[5];
  assign dig6  = dig_q[6];
  assign dig7  = dig_q[7];
  assign dig8  = dig_q[8];
  assign dig9  = dig_q[9];
  assign dig10 = dig_q[10];

endmodule

// File: tb/tb_bin2bcd_11dig.sv
// Directed bench for bin2bcd_11dig: reset, boundary values, ignored starts,
// mid-conversion reset and a long back-to-back run against a decimal model.
module tb_bin2bcd_11dig;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [35:0] bin = '0;
  logic        ready, done_tick;
  logic [3:0]  dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7, dig8, dig9, dig10;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  bin2bcd_11dig dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .ready(ready), .done_tick(done_tick),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5),
    .dig6(dig6), .dig7(dig7), .dig8(dig8), .dig9(dig9), .dig10(dig10),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [43:0] bcd_ref(input logic [35:0] b);
    longint unsigned v;
    logic [43:0] r;
    v = 64'(b);
    r = '0;
    for (int i = 0; i < 11; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [43:0] digs();
    return {dig10, dig9, dig8, dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
  endfunction

  // Driver: start at E0, bin switched to alt right after, optional start pulses
  // at cycles p1/p2; records the done cycle, done count, ready-high count and result.
  task automatic convert(input logic [35:0] b, input logic [35:0] alt,
                         input int p1, input int p2,
                         output int done_cyc, output int n_done, output int n_ready_hi,
                         output logic [43:0] res, output logic ready_after);
    done_cyc = 0; n_done = 0; n_ready_hi = 0; res = '0; ready_after = 1'b0;
    @(negedge clk);
    bin = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (done_tick) begin
        n_done++;
        done_cyc = c;
        res = digs();
      end
      if (c <= 37 && ready) n_ready_hi++;
      if (c == 38) ready_after = ready;
      bin = alt;
      start = (c == p1 || c == p2) && (c < 38);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
    total++;
    if (done_tick !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_tick); end
    total++;
    if (digs() !== 44'h0) begin bad++; $display("FAIL reset_digits: got %h expected 0", digs()); end
    total++;
    if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    int dc, nd, nr;
    logic [43:0] res;
    logic ra;
    convert(36'hF_FFFF_FFFF, 36'h0_1234_5678, 0, 0, dc, nd, nr, res, ra);
    total++;
    if (res !== 44'h68719476735) begin bad++; $display("FAIL max_digits: got %h expected 68719476735", res); end
    total++;
    if (dc !== 37) begin bad++; $display("FAIL max_latency: got %0d expected 37", dc); end
  endtask

  task automatic test_zero();
    int dc, nd, nr;
    logic [43:0] res;
    logic ra;
    convert(36'd0, 36'h9_8765_4321, 0, 0, dc, nd, nr, res, ra);
    total++;
    if (dc !== 37) begin bad++; $display("FAIL zero_done_cycle: got %0d expected 37", dc); end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
    total++;
    if (nr !== 0) begin bad++; $display("FAIL zero_ready_low: ready high in %0d cycles, expected 0", nr); end
    total++;
    if (res !== 44'h0) begin bad++; $display("FAIL zero_digits: got %h expected 0", res); end
    total++;
    if (ra !== 1'b1) begin bad++; $display("FAIL zero_ready_after: got %b expected 1", ra); end
  endtask

  task automatic test_hold();
    int dc, nd, nr;
    logic [43:0] res;
    logic ra;
    convert(36'd1234567890, 36'd5, 0, 0, dc, nd, nr, res, ra);
    total++;
    if (res !== 44'h01234567890) begin bad++; $display("FAIL dec_digits: got %h expected 01234567890", res); end
    total++;
    if (dc !== 37) begin bad++; $display("FAIL dec_latency: got %0d expected 37", dc); end
    for (int i = 0; i < 10; i++) begin
      bin = {4'($urandom_range(0, 15)), 32'($urandom())};
      @(negedge clk);
      total++;
      if (digs() !== 44'h01234567890) begin
        bad++; $display("FAIL dec_hold: got %h expected 01234567890", digs());
      end
    end
  endtask

  task automatic test_ignored_start();
    int dc, nd, nr;
    logic [43:0] res;
    logic ra;
    convert(36'd987654321, 36'd111, 5, 36, dc, nd, nr, res, ra);
    total++;
    if (res !== 44'h00987654321) begin bad++; $display("FAIL repulse_digits: got %h expected 00987654321", res); end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL repulse_done_count: got %0d expected 1", nd); end
    total++;
    if (dc !== 37) begin bad++; $display("FAIL repulse_latency: got %0d expected 37", dc); end
    // start raised in the done cycle must not launch a new conversion
    convert(36'd42, 36'd7, 37, 0, dc, nd, nr, res, ra);
    total++;
    if (res !== 44'h42) begin bad++; $display("FAIL donestart_digits: got %h expected 42", res); end
    total++;
    if (ra !== 1'b1) begin bad++; $display("FAIL donestart_ready: got %b expected 1", ra); end
    @(negedge clk);
    total++;
    if (digs() !== 44'h42) begin bad++; $display("FAIL donestart_hold: got %h expected 42", digs()); end
  endtask

  task automatic test_reset_mid();
    int dc, nd, nr;
    logic [43:0] res;
    logic ra;
    int seen;
    @(negedge clk);
    bin = 36'hF_FFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (digs() !== 44'h0) begin bad++; $display("FAIL midrst_digits: got %h expected 0", digs()); end
    total++;
    if (ready !== 1'b1 || done_tick !== 1'b0) begin
      bad++; $display("FAIL midrst_flags: got ready=%b done=%b expected ready=1 done=0", ready, done_tick);
    end
    total++;
    if (fsm_state !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d expected 0", fsm_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (fsm_state !== 2'd0 || ready !== 1'b1) begin
      bad++; $display("FAIL midrst_release: got state=%0d ready=%b expected 0/1", fsm_state, ready);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_tick) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d done ticks expected 0", seen); end
    convert(36'd999, 36'd123, 0, 0, dc, nd, nr, res, ra);
    total++;
    if (res !== 44'h999) begin bad++; $display("FAIL midrst_999: got %h expected 999", res); end
    total++;
    if (dc !== 37) begin bad++; $display("FAIL midrst_latency: got %0d expected 37", dc); end
  endtask

  task automatic test_back_to_back();
    logic [43:0] exp_q[$];
    logic [43:0] exp;
    int cyc, last, n_done, pushes;
    cyc = 0; last = 0; n_done = 0; pushes = 0;
    start = 1'b0;
    while (n_done < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (done_tick) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          exp = exp_q.pop_front();
          if (digs() !== exp) begin bad++; $display("FAIL b2b_digits: got %h expected %h", digs(), exp); end
        end
        if (last > 0) begin
          total++;
          if (cyc - last !== 38) begin bad++; $display("FAIL b2b_period: got %0d expected 38", cyc - last); end
        end
        last = cyc;
        n_done++;
      end
      if (ready) begin
        if (pushes < 1000) begin
          bin = {4'($urandom_range(0, 15)), 32'($urandom())};
          exp_q.push_back(bcd_ref(bin));
          pushes++;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++;
    if (n_done !== 1000) begin bad++; $display("FAIL b2b_timeout: got %0d conversions expected 1000", n_done); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_hold();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_11dig.md
BIN2BCD_11DIG -- requirements
Module: bin2bcd_11dig

Interface
REQ-001 The block SHALL have the parameter BIN_W, default 36, meaning the binary input width.
REQ-002 The block SHALL have the parameter NDIG, default 11, meaning the BCD output digit count; it is fixed at 11 because 2^36-1 = 68,719,476,735 fits in 11 digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to convert bin; it is sampled only in idle.
REQ-006 The block SHALL have port bin, input, BIN_W bits: the unsigned binary value, captured on the edge that accepts start.
REQ-007 The block SHALL have port ready, output, 1 bit: high while the FSM is in idle.
REQ-008 The block SHALL have port done_tick, output, 1 bit: a one-cycle pulse when the conversion result is valid.
REQ-009 The block SHALL have ports dig0..dig10, output, 4 bits each: BCD digits, dig0 least significant, direct register outputs.

Function
REQ-010 The FSM SHALL have the states idle, op and done.
REQ-011 In idle with start=1 at rising edge E0, the block SHALL capture bin into a BIN_W-bit shift register, clear all digit registers to 0, load iteration counter n=BIN_W, and enter op.
REQ-012 In op, each edge SHALL: first add 3 to every digit whose value exceeds 4; then shift {dig10..dig0, shift register} left by 1, with the shift register MSB entering dig0 bit 0; then decrement n.
REQ-013 The edge at which n=1 is decremented SHALL also move the FSM to done, so exactly BIN_W shifts occur, on edges E1..E36.
REQ-014 In done, done_tick SHALL be 1 for exactly one cycle (the cycle after E36), and the next edge SHALL return the FSM to idle.
REQ-015 Latency SHALL be BIN_W+1 cycles: done_tick high in the 37th cycle after E0.
REQ-016 dig0..dig10 SHALL hold their final values from done until the next accepted start.
REQ-017 start while in op or done SHALL be ignored, and bin changes after E0 SHALL have no effect.
REQ-018 start high during the done cycle SHALL NOT be accepted; a new conversion is accepted earliest in the cycle after done_tick, giving back-to-back throughput of one conversion per BIN_W+2 cycles.
REQ-019 Each digit SHALL be 4 bits wide and never exceed 9 after any op edge; the pre-shift add-3 result SHALL be at most 12 and stay within 4 bits.
REQ-020 The carry out of dig10 bit 3 SHALL be discarded; it is provably zero for BIN_W=36.
REQ-021 A value of 0 SHALL produce all digits 0 after a full 36-cycle conversion, with no early exit.
REQ-022 The counter n SHALL be ceil(log2(BIN_W+1)) bits wide.

Reset
REQ-023 When rst_n is low, the block SHALL asynchronously force state=idle, ready=1, done_tick=0, all digits=0, shift register=0 and n=0.
REQ-024 A reset asserted mid-conversion SHALL abort the conversion with no done_tick, and the FSM SHALL be in idle on the first edge after rst_n is released.

Structure
REQ-025 The shared package SHALL hold BIN_W, NDIG, the state encodings (idle=2'd0, op=2'd1, done=2'd2) and a BCD digit typedef (4 bits).
REQ-026 The design SHALL use one sub-module, bcd_adj3 (combinational: output = in>4 ? in+3 : in), instanced NDIG times inside a generate loop.
REQ-027 An unused state encoding SHALL return the FSM to idle.
REQ-028 Outputs dig0..dig10 SHALL connect directly to the downstream normaliser's digit inputs, and done_tick SHALL drive its start input.

Verification
REQ-029 The bench SHALL check: bin=0, start pulse at E0 -> done_tick only in cycle 37, all digits 0, ready low during cycles 1-37.
REQ-030 The bench SHALL check: bin=36'hF_FFFF_FFFF -> digits dig10..dig0 = 6,8,7,1,9,4,7,6,7,3,5.
REQ-031 The bench SHALL check: bin=1,234,567,890 -> dig10=0, dig9..dig0 = 1,2,3,4,5,6,7,8,9,0; digits hold after done_tick while bin is randomised.
REQ-032 The bench SHALL check: start re-pulsed at cycles 5 and 36 with different bin -> ignored, the original result appears, and exactly one done_tick occurs.
REQ-033 The bench SHALL check: rst_n low at cycle 20 of a conversion -> all outputs 0 immediately, no done_tick; after release, start with bin=999 gives dig2..dig0 = 9,9,9 in cycle 37.
REQ-034 The bench SHALL check: back-to-back starts held high continuously -> done_tick every 38 cycles, results correct against a reference model for 1000 random bin values.
